// File: rtl/cam_vector_feeder.sv
// cam_vector_feeder: buffers host vectors in a small FIFO and feeds them one
// at a time to CAM_Data_Store, pacing itself on the store's done/done_all.
module cam_vector_feeder #(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] vec_in,
  input  logic        vec_valid,
  output logic        vec_ready,
  input  logic        job_start,
  input  logic [4:0]  job_base,
  input  logic [3:0]  job_count,
  output logic [15:0] data_in,
  output logic [4:0]  cmp_addr_high,
  output logic [3:0]  num_vectors,
  output logic        store_start,
  input  logic        done,
  input  logic        done_all,
  output logic        busy,
  output logic        job_done,
  output logic [4:0]  fifo_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL_LEVEL = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PRESENT,
    FINAL
  } state_t;

  state_t state;
  state_t state_next;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    vec_cnt;

  logic push;
  logic pop;
  logic latch_job;
  logic finish_job;
  logic last_vec;

  assign vec_ready = (fifo_level != FULL_LEVEL);
  assign push      = vec_valid && vec_ready;
  assign last_vec  = (vec_cnt == num_vectors);

  // FIFO storage: the write side owns the array, reads happen in the datapath block
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= vec_in;
    end
  end

  // FIFO pointers wrap naturally at DEPTH; occupancy is tracked separately so full and empty stay distinct
  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 5'd1;
        2'b01:   fifo_level <= fifo_level - 5'd1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Job sequencer state register
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: stall in LOAD on an empty FIFO, and let a done_all that lands with the last done skip FINAL
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (job_start && (job_count != 4'd0)) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (fifo_level != 5'd0) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (done) begin
          if (last_vec) begin
            state_next = done_all ? IDLE : FINAL;
          end else begin
            state_next = LOAD;
          end
        end
      end
      FINAL: begin
        if (done_all) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-state control strobes that drive the FIFO and the output registers
  always_comb begin
    busy       = (state != IDLE);
    pop        = 1'b0;
    latch_job  = 1'b0;
    finish_job = 1'b0;
    case (state)
      IDLE:    latch_job  = job_start;
      LOAD:    pop        = (fifo_level != 5'd0);
      PRESENT: finish_job = done && last_vec && done_all;
      FINAL:   finish_job = done_all;
      default: begin
        pop        = 1'b0;
        latch_job  = 1'b0;
        finish_job = 1'b0;
      end
    endcase
  end

  // Store-facing registers: job parameters latched at start, data held between pops, one-cycle pulses
  always_ff @(posedge CLK) begin
    if (rst) begin
      data_in       <= '0;
      cmp_addr_high <= '0;
      num_vectors   <= '0;
      vec_cnt       <= '0;
      store_start   <= 1'b0;
      job_done      <= 1'b0;
    end else begin
      store_start <= pop;
      job_done    <= finish_job || (latch_job && (job_count == 4'd0));
      if (latch_job) begin
        cmp_addr_high <= job_base;
        num_vectors   <= job_count;
        vec_cnt       <= '0;
      end
      if (pop) begin
        data_in <= mem[rd_ptr];
        vec_cnt <= vec_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_cam_vector_feeder.sv
// tb_cam_vector_feeder: directed stimulus with a scoreboard of expected vectors
// and a monitor that checks every store_start presentation.
module tb_cam_vector_feeder;

  logic        CLK;
  logic        rst;
  logic [15:0] vec_in;
  logic        vec_valid;
  logic        vec_ready;
  logic        job_start;
  logic [4:0]  job_base;
  logic [3:0]  job_count;
  logic [15:0] data_in;
  logic [4:0]  cmp_addr_high;
  logic [3:0]  num_vectors;
  logic        store_start;
  logic        done;
  logic        done_all;
  logic        busy;
  logic        job_done;
  logic [4:0]  fifo_level;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_data [$];
  logic [4:0]  exp_base;
  logic [3:0]  exp_count;
  int          exp_jobs;
  int          job_done_cnt = 0;
  int          store_cnt    = 0;

  int done_delay;
  bit coincide;
  int resp_timer   = 0;
  int resp_seen    = 0;
  int resp_final   = 0;
  bit resp_pending = 0;
  bit resp_chk     = 0;

  logic [15:0] stall_vecs [3] = '{16'h0123, 16'h4567, 16'h89AB};

  cam_vector_feeder #(.DEPTH(8)) dut (
    .CLK           (CLK),
    .rst           (rst),
    .vec_in        (vec_in),
    .vec_valid     (vec_valid),
    .vec_ready     (vec_ready),
    .job_start     (job_start),
    .job_base      (job_base),
    .job_count     (job_count),
    .data_in       (data_in),
    .cmp_addr_high (cmp_addr_high),
    .num_vectors   (num_vectors),
    .store_start   (store_start),
    .done          (done),
    .done_all      (done_all),
    .busy          (busy),
    .job_done      (job_done),
    .fifo_level    (fifo_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: timed out, got no response, expected completion", name);
  endtask

  // push one vector, waiting (bounded) for vec_ready; returns on the negedge after the push edge
  task automatic applyStimulus(input logic [15:0] v);
    int waited = 0;
    vec_in    = v;
    vec_valid = 1'b1;
    while (!vec_ready && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    if (!vec_ready) begin
      reportTimeout("push");
    end else begin
      exp_data.push_back(v);
    end
    @(negedge CLK);
    vec_valid = 1'b0;
  endtask

  task automatic startJob(input logic [4:0] b, input logic [3:0] c, input bit accept);
    job_base  = b;
    job_count = c;
    job_start = 1'b1;
    if (accept) begin
      exp_base  = b;
      exp_count = c;
      exp_jobs++;
    end
    @(negedge CLK);
    job_start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (busy) begin
      reportTimeout(name);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic checkResetValues();
    checkOutput("reset data_in", 32'(data_in), 32'h0);
    checkOutput("reset cmp_addr_high", 32'(cmp_addr_high), 32'h0);
    checkOutput("reset num_vectors", 32'(num_vectors), 32'h0);
    checkOutput("reset store_start", 32'(store_start), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset job_done", 32'(job_done), 32'h0);
    checkOutput("reset fifo_level", 32'(fifo_level), 32'h0);
    checkOutput("reset vec_ready", 32'(vec_ready), 32'h1);
  endtask

  // monitor: every store_start must present the oldest expected vector with the current job parameters
  initial begin
    forever begin
      @(negedge CLK);
      if (store_start) begin
        store_cnt++;
        if (exp_data.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected store_start: data_in 0x%0h, expected no presentation", data_in);
        end else begin
          checkOutput("data_in", 32'(data_in), 32'(exp_data.pop_front()));
        end
        checkOutput("cmp_addr_high", 32'(cmp_addr_high), 32'(exp_base));
        checkOutput("num_vectors", 32'(num_vectors), 32'(exp_count));
      end
      if (job_done) begin
        job_done_cnt++;
      end
    end
  end

  // store model: answers each store_start with done after done_delay, then done_all on the last vector
  initial begin
    done     = 1'b0;
    done_all = 1'b0;
    forever begin
      @(negedge CLK);
      done     = 1'b0;
      done_all = 1'b0;
      if (resp_chk) begin
        checkOutput("job_done after done_all", 32'(job_done), 32'h1);
        checkOutput("busy after done_all", 32'(busy), 32'h0);
        resp_chk = 0;
      end
      if (!busy) begin
        resp_pending = 0;
        resp_final   = 0;
        resp_seen    = 0;
      end else if (resp_pending) begin
        if (resp_timer == 0) begin
          done         = 1'b1;
          resp_pending = 0;
          if (resp_seen == int'(exp_count)) begin
            if (coincide) begin
              done_all = 1'b1;
              resp_chk = 1;
            end else begin
              resp_final = 3;
            end
          end
        end else begin
          resp_timer--;
        end
      end else if (resp_final > 0) begin
        resp_final--;
        if (resp_final == 0) begin
          done_all = 1'b1;
          resp_chk = 1;
        end
      end
      if (store_start) begin
        resp_pending = 1;
        resp_timer   = done_delay;
        resp_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    vec_in     = '0;
    vec_valid  = 1'b0;
    job_start  = 1'b0;
    job_base   = '0;
    job_count  = '0;
    done_delay = 40;
    coincide   = 0;
    exp_jobs   = 0;
    exp_base   = '0;
    exp_count  = '0;
    repeat (3) @(negedge CLK);
    checkResetValues();
    rst = 1'b0;
    @(negedge CLK);

    // basic two-vector job
    store_cnt = 0;
    applyStimulus(16'hE26F);
    applyStimulus(16'hF89B);
    checkOutput("level after two pushes", 32'(fifo_level), 32'h2);
    startJob(5'b00001, 4'd2, 1);
    checkOutput("busy after job_start", 32'(busy), 32'h1);
    checkOutput("no store_start at T+1", 32'(store_start), 32'h0);
    @(negedge CLK);
    checkOutput("store_start at T+2", 32'(store_start), 32'h1);
    waitIdle("basic job");
    checkOutput("basic store_start count", 32'(store_cnt), 32'h2);
    checkOutput("basic job_done count", 32'(job_done_cnt), 32'(exp_jobs));
    checkOutput("basic final level", 32'(fifo_level), 32'h0);

    // empty-FIFO stall, vectors trickle in
    done_delay = 5;
    store_cnt  = 0;
    startJob(5'd2, 4'd3, 1);
    repeat (20) @(negedge CLK);
    checkOutput("stall busy", 32'(busy), 32'h1);
    checkOutput("stall no delivery", 32'(store_cnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(stall_vecs[i]);
      checkOutput("store_start not at push+1", 32'(store_start), 32'h0);
      @(negedge CLK);
      checkOutput("store_start at push+2", 32'(store_start), 32'h1);
      repeat (20) @(negedge CLK);
    end
    waitIdle("stall job");
    checkOutput("stall store_start count", 32'(store_cnt), 32'h3);
    checkOutput("stall job_done count", 32'(job_done_cnt), 32'(exp_jobs));

    // full FIFO, push held across a pop, pointer wrap
    done_delay = 10;
    store_cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16'hA000 + 16'(i));
    end
    checkOutput("full level", 32'(fifo_level), 32'h8);
    checkOutput("full vec_ready", 32'(vec_ready), 32'h0);
    startJob(5'd3, 4'd4, 1);
    vec_in    = 16'hA008;
    vec_valid = 1'b1;
    checkOutput("held push level 8", 32'(fifo_level), 32'h8);
    @(negedge CLK);
    checkOutput("pop level 7", 32'(fifo_level), 32'h7);
    checkOutput("ready after pop", 32'(vec_ready), 32'h1);
    exp_data.push_back(16'hA008);
    @(negedge CLK);
    vec_valid = 1'b0;
    checkOutput("refill level 8", 32'(fifo_level), 32'h8);
    for (int i = 9; i < 12; i++) begin
      applyStimulus(16'hA000 + 16'(i));
    end
    waitIdle("full job 1");
    checkOutput("level after first drain", 32'(fifo_level), 32'h8);
    startJob(5'd4, 4'd8, 1);
    waitIdle("full job 2");
    checkOutput("wrap store_start count", 32'(store_cnt), 32'd12);
    checkOutput("wrap final level", 32'(fifo_level), 32'h0);
    checkOutput("wrap job_done count", 32'(job_done_cnt), 32'(exp_jobs));

    // zero-count job, then a start ignored while presenting
    done_delay = 30;
    store_cnt  = 0;
    startJob(5'd6, 4'd0, 1);
    checkOutput("zero-count job_done", 32'(job_done), 32'h1);
    checkOutput("zero-count busy", 32'(busy), 32'h0);
    applyStimulus(16'hB1B1);
    startJob(5'd7, 4'd1, 1);
    repeat (6) @(negedge CLK);
    startJob(5'd9, 4'd5, 0);
    checkOutput("ignored start num_vectors", 32'(num_vectors), 32'h1);
    checkOutput("ignored start cmp_addr_high", 32'(cmp_addr_high), 32'h7);
    waitIdle("ignored start job");
    checkOutput("zero/ignored store_start count", 32'(store_cnt), 32'h1);
    checkOutput("zero/ignored job_done count", 32'(job_done_cnt), 32'(exp_jobs));

    // last done coinciding with done_all
    done_delay = 8;
    coincide   = 1;
    store_cnt  = 0;
    applyStimulus(16'hC1C1);
    applyStimulus(16'hC2C2);
    startJob(5'd10, 4'd2, 1);
    waitIdle("coincide job");
    checkOutput("coincide store_start count", 32'(store_cnt), 32'h2);
    checkOutput("coincide job_done count", 32'(job_done_cnt), 32'(exp_jobs));
    checkOutput("coincide busy stays low", 32'(busy), 32'h0);

    // reset in the middle of a job
    coincide   = 0;
    done_delay = 50;
    applyStimulus(16'hD1D1);
    applyStimulus(16'hD2D2);
    startJob(5'd11, 4'd2, 1);
    repeat (4) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    checkResetValues();
    exp_data.delete();
    exp_jobs--;
    repeat (3) @(negedge CLK);
    checkOutput("no job_done on reset", 32'(job_done_cnt), 32'(exp_jobs));
    done_delay = 5;
    store_cnt  = 0;
    applyStimulus(16'hE1E1);
    startJob(5'd12, 4'd1, 1);
    waitIdle("post-reset job");
    checkOutput("post-reset store_start count", 32'(store_cnt), 32'h1);
    checkOutput("post-reset job_done count", 32'(job_done_cnt), 32'(exp_jobs));
    checkOutput("post-reset final level", 32'(fifo_level), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
